// File: rtl/mult_div_e_pkg.sv
// Shared definitions for the E-stage multiply/divide unit.
// Holds the md_op encoding, default latencies, the MFHI/MFLO result-select
// code used by the E-stage result mux, and the unit's FSM state type.
package mult_div_e_pkg;

    // md_op encoding (3 bits); 7 is reserved and behaves like MD_NONE.
    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    // Default busy latencies; legal range is 1..31.
    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;
    localparam int unsigned CNT_W           = 5;

    // E-stage result mux select for MFHI/MFLO.
    localparam logic RES_SEL_LO = 1'b0;
    localparam logic RES_SEL_HI = 1'b1;

    typedef enum logic {
        StIdle,
        StBusy
    } md_state_e;

endpackage

// File: rtl/mult_div_e_md_compute.sv
// Combinational multiply/divide datapath.
// Ports:
//   i_md_op  - operation select (mult_div_e_pkg encoding)
//   i_src_a  - rs operand (dividend / multiplicand)
//   i_src_b  - rt operand (divisor / multiplier)
//   o_result - {hi, lo}; divides give {remainder, quotient}
module mult_div_e_md_compute
    import mult_div_e_pkg::*;
(
    input  logic [2:0]  i_md_op,
    input  logic [31:0] i_src_a,
    input  logic [31:0] i_src_b,
    output logic [63:0] o_result
);

    logic        w_div_zero;
    logic        w_div_ovf;
    logic [31:0] w_div_b;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_quot_s;
    logic [31:0] w_rem_s;
    logic [31:0] w_quot_u;
    logic [31:0] w_rem_u;

    assign w_div_zero = (i_src_b == 32'd0);
    assign w_div_ovf  = (i_src_a == 32'h8000_0000) && (i_src_b == 32'hFFFF_FFFF);

    // Substitute a harmless divisor in the two special cases so the divider
    // never sees x/0 or INT_MIN/-1; those results are selected explicitly.
    assign w_div_b = (w_div_zero || w_div_ovf) ? 32'd1 : i_src_b;

    // Low 64 bits of the sign-extended product equal the signed 32x32 product.
    assign w_prod_s = {{32{i_src_a[31]}}, i_src_a} * {{32{i_src_b[31]}}, i_src_b};
    assign w_prod_u = {32'd0, i_src_a} * {32'd0, i_src_b};

    // SystemVerilog signed / and % already truncate toward zero with the
    // remainder taking the dividend's sign.
    assign w_quot_s = $unsigned($signed(i_src_a) / $signed(w_div_b));
    assign w_rem_s  = $unsigned($signed(i_src_a) % $signed(w_div_b));
    assign w_quot_u = i_src_a / w_div_b;
    assign w_rem_u  = i_src_a % w_div_b;

    always_comb begin
        o_result = '0;
        case (i_md_op)
            MD_MULT:  o_result = w_prod_s;
            MD_MULTU: o_result = w_prod_u;
            MD_DIV: begin
                if (w_div_zero) begin
                    o_result = {i_src_a, 32'hFFFF_FFFF};
                end else if (w_div_ovf) begin
                    o_result = {32'd0, 32'h8000_0000};
                end else begin
                    o_result = {w_rem_s, w_quot_s};
                end
            end
            MD_DIVU: begin
                if (w_div_zero) begin
                    o_result = {i_src_a, 32'hFFFF_FFFF};
                end else begin
                    o_result = {w_rem_u, w_quot_u};
                end
            end
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/mult_div_e.sv
// E-stage multiply/divide unit holding architectural HI/LO.
// The result is computed at accept time into a pending register; a counter
// then models the fixed latency and HI/LO commit on the edge busy falls.
// Ports:
//   i_clk    - pipeline clock, rising edge
//   i_reset  - asynchronous active-high reset, clears all state
//   i_start  - E-stage instruction is a valid MD op
//   i_cancel - E-stage instruction is being flushed; suppresses i_start
//   i_md_op  - operation select (mult_div_e_pkg encoding)
//   i_src_a  - forwarded rs value
//   i_src_b  - forwarded rt value
//   o_busy   - multi-cycle operation in flight
//   o_hi     - architectural HI
//   o_lo     - architectural LO
module mult_div_e
    import mult_div_e_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_cancel,
    input  logic [2:0]  i_md_op,
    input  logic [31:0] i_src_a,
    input  logic [31:0] i_src_b,
    output logic        o_busy,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

    md_state_e        r_state;
    logic [CNT_W-1:0] r_count;
    logic [63:0]      r_pending;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic [63:0]      w_result;
    logic             w_accept;

    mult_div_e_md_compute u_md_compute (
        .i_md_op  (i_md_op),
        .i_src_a  (i_src_a),
        .i_src_b  (i_src_b),
        .o_result (w_result)
    );

    // Starts are only honoured from StIdle, so a start while busy is dropped.
    assign w_accept = i_start && !i_cancel;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= StIdle;
            r_count   <= '0;
            r_pending <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        case (i_md_op)
                            MD_MTHI: r_hi <= i_src_a;
                            MD_MTLO: r_lo <= i_src_a;
                            MD_MULT, MD_MULTU: begin
                                r_pending <= w_result;
                                r_count   <= MULT_N;
                                r_state   <= StBusy;
                            end
                            MD_DIV, MD_DIVU: begin
                                r_pending <= w_result;
                                r_count   <= DIV_N;
                                r_state   <= StBusy;
                            end
                            default: ;
                        endcase
                    end
                end
                StBusy: begin
                    // Last busy cycle: commit and drop busy on the same edge.
                    if (r_count == CNT_W'(1)) begin
                        r_hi    <= r_pending[63:32];
                        r_lo    <= r_pending[31:0];
                        r_count <= '0;
                        r_state <= StIdle;
                    end else begin
                        r_count <= r_count - CNT_W'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_busy = (r_state == StBusy);
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: tb/tb_mult_div_e.sv
// Self-checking bench for mult_div_e: directed cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_mult_div_e;
    import mult_div_e_pkg::*;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        cancel;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    wire         busy;
    wire  [31:0] hi;
    wire  [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mult_div_e #(
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_start  (start),
        .i_cancel (cancel),
        .i_md_op  (md_op),
        .i_src_a  (src_a),
        .i_src_b  (src_b),
        .o_busy   (busy),
        .o_hi     (hi),
        .o_lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Hazard control must never present a start while busy.
    always @(posedge clk) begin
        if (reset === 1'b0) check_eq("no_start_while_busy", {63'd0, start & busy}, 64'd0);
    end

    // Reference model: {hi, lo} from the architectural rules using wide integers.
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] va,
                                           input logic [31:0] vb);
        longint      sa, sb, ma, mb, q, r;
        int          ia, ib;
        logic [63:0] u, qv, rv;
        ia = int'(va);
        ib = int'(vb);
        sa = longint'(ia);
        sb = longint'(ib);
        u  = '0;
        case (op)
            MD_MULT: begin
                q = sa * sb;
                u = q;
            end
            MD_MULTU: u = {32'd0, va} * {32'd0, vb};
            MD_DIV: begin
                if (vb == 32'd0) begin
                    u = {va, 32'hFFFF_FFFF};
                end else begin
                    ma = (sa < 0) ? -sa : sa;
                    mb = (sb < 0) ? -sb : sb;
                    q  = ma / mb;
                    if ((sa < 0) != (sb < 0)) q = -q;
                    r  = sa - q * sb;
                    qv = q;
                    rv = r;
                    u  = {rv[31:0], qv[31:0]};
                end
            end
            MD_DIVU: begin
                if (vb == 32'd0) u = {va, 32'hFFFF_FFFF};
                else             u = {va % vb, va / vb};
            end
            default: u = '0;
        endcase
        return u;
    endfunction

    // Called at a negedge; drives one op and returns at the negedge after
    // completion, so consecutive calls are back-to-back.
    task automatic run_op(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb,
                          input logic vc, input string tag);
        int unsigned n;
        logic [63:0] r;
        start  = 1'b1;
        cancel = vc;
        md_op  = op;
        src_a  = va;
        src_b  = vb;
        n = 0;
        if (!vc) begin
            if (op == MD_MULT || op == MD_MULTU) n = MC;
            if (op == MD_DIV || op == MD_DIVU)   n = DC;
        end
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        md_op  = 3'($urandom);
        src_a  = $urandom;
        src_b  = $urandom;
        if (n == 0) begin
            if (!vc && op == MD_MTHI) m_hi = va;
            if (!vc && op == MD_MTLO) m_lo = va;
            check_eq({tag, "_busy"}, {63'd0, busy}, 64'd0);
        end else begin
            r = ref_md(op, va, vb);
            for (int k = 0; k < int'(n); k++) begin
                check_eq({tag, "_busy"}, {63'd0, busy}, 64'd1);
                check_eq({tag, "_hold"}, {hi, lo}, {m_hi, m_lo});
                cancel = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            cancel = 1'b0;
            m_hi = r[63:32];
            m_lo = r[31:0];
            check_eq({tag, "_done"}, {63'd0, busy}, 64'd0);
        end
        check_eq({tag, "_hi"}, {32'd0, hi}, {32'd0, m_hi});
        check_eq({tag, "_lo"}, {32'd0, lo}, {32'd0, m_lo});
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] va, vb;
        logic        vc;
        reset  = 1'b0;
        start  = 1'b0;
        cancel = 1'b0;
        md_op  = MD_NONE;
        src_a  = '0;
        src_b  = '0;
        m_hi   = '0;
        m_lo   = '0;
        #1 reset = 1'b1;
        #1;
        check_eq("reset_busy", {63'd0, busy}, 64'd0);
        check_eq("reset_hilo", {hi, lo}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Directed cases; expected values are fixed constants.
        run_op(MD_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, "mult_neg1x2");
        check_eq("mult_neg1x2_k", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, "multu_ffx2");
        check_eq("multu_ffx2_k", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7by2");
        check_eq("div_m7by2_k", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(MD_DIVU, 32'd7, 32'd0, 1'b0, "divu_by0");
        check_eq("divu_by0_k", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        check_eq("div_ovf_k", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op(MD_MTHI, 32'h1234_5678, 32'd0, 1'b0, "mthi");
        check_eq("mthi_k", {hi, lo}, 64'h1234_5678_8000_0000);
        run_op(MD_MULT, 32'd3, 32'd4, 1'b1, "mult_cancel");
        check_eq("mult_cancel_k", {hi, lo}, 64'h1234_5678_8000_0000);
        run_op(MD_MULT, 32'd3, 32'd4, 1'b0, "mult_3x4");
        check_eq("mult_3x4_k", {hi, lo}, 64'd12);
        run_op(MD_MULT, 32'h0001_0000, 32'h0003_0000, 1'b0, "mult_b2b");
        run_op(MD_MTLO, 32'h0000_AAAA, 32'd0, 1'b0, "mtlo_b2b");
        check_eq("mtlo_b2b_k", {hi, lo}, 64'h0000_0003_0000_AAAA);

        // Reset during cycle 3 of a DIV.
        start = 1'b1; md_op = MD_DIV; src_a = 32'd100; src_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq("rst_mid_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_mid_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        for (int k = 0; k < int'(DC) + 4; k++) begin
            @(negedge clk);
            check_eq("rst_no_commit", {31'd0, busy, hi, lo}, 64'd0);
        end

        // Randomized ops, including special divide operands and no-op encodings.
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            va = $urandom;
            vb = $urandom;
            case ($urandom_range(0, 7))
                0: vb = 32'd0;
                1: begin va = 32'h8000_0000; vb = 32'hFFFF_FFFF; end
                2: begin va = $urandom_range(0, 50); vb = $urandom_range(1, 9); end
                3: vb = -$urandom_range(1, 9);
                default: ;
            endcase
            vc = ($urandom_range(0, 4) == 0);
            run_op(op, va, vb, vc, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
